// File: rtl/uart_pkg.sv
// uart_pkg: shared types and widths for the UART receive path.
//   rx_state_t     - receiver FSM states
//   UART_DATA_BITS - data bits per 8N1 frame
//   UART_DATA_EXT  - width of the zero-extended word handed to writeback
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
    localparam int UART_DATA_BITS = 8;
    localparam int UART_DATA_EXT = 32;
endpackage

// File: rtl/uart_input_buffer_if.sv
// uart_input_buffer_if: writeback-side bus of the UART input buffer.
//   read_enable   - pop FIFO head (writeback -> buffer)
//   err_clear     - clear sticky error flags (writeback -> buffer)
//   input_ready   - FIFO non-empty (buffer -> writeback)
//   input_data    - zero-extended head byte (buffer -> writeback)
//   overrun       - sticky byte-dropped flag (buffer -> writeback)
//   framing_error - sticky bad-stop-bit flag (buffer -> writeback)
interface uart_input_buffer_if;
    import uart_pkg::*;
    logic read_enable;
    logic err_clear;
    logic input_ready;
    logic [UART_DATA_EXT-1:0] input_data;
    logic overrun;
    logic framing_error;
    modport master (output read_enable, err_clear, input input_ready, input_data, overrun, framing_error);
    modport slave (input read_enable, err_clear, output input_ready, input_data, overrun, framing_error);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular byte FIFO of 2^FIFO_WIDTH entries.
//   clk, reset     - clock, synchronous active-low reset
//   push/push_data - write a byte (accepted when not full, or when full with a pop)
//   pop            - advance head (ignored when empty)
//   head           - current head byte
//   empty, full    - occupancy status
module uart_rx_fifo import uart_pkg::*; #(
    parameter int FIFO_WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic [UART_DATA_BITS-1:0] push_data,
    input  logic pop,
    output logic [UART_DATA_BITS-1:0] head,
    output logic empty,
    output logic full
);
    localparam int DEPTH = 1 << FIFO_WIDTH;
    localparam logic [FIFO_WIDTH:0] LAST = (FIFO_WIDTH + 1)'(DEPTH - 1);
    localparam logic [FIFO_WIDTH:0] DEPTH_C = (FIFO_WIDTH + 1)'(DEPTH);

    logic [UART_DATA_BITS-1:0] mem [DEPTH];
    logic [FIFO_WIDTH:0] wr_ptr, rd_ptr, count;
    logic do_push, do_pop;

    assign empty = count == '0;
    assign full = count == DEPTH_C;
    assign do_pop = pop & ~empty;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_push = push & (~full | do_pop);
    assign head = mem[rd_ptr[FIFO_WIDTH-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[FIFO_WIDTH-1:0]] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            count <= count + {{FIFO_WIDTH{1'b0}}, do_push} - {{FIFO_WIDTH{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/uart_input_buffer.sv
// uart_input_buffer: 8N1 UART receiver feeding a byte FIFO read by the writeback stage.
//   clk, reset - clock, synchronous active-low reset
//   rxd        - asynchronous serial input, idle high
//   bus        - writeback-side handshake (read_enable, err_clear, input_ready,
//                input_data, overrun, framing_error)
module uart_input_buffer import uart_pkg::*; #(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic rxd,
    uart_input_buffer_if.slave bus
);
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] BIT_LOAD = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_PER_BIT / 2 - 1);

    logic rx_meta, rx_s;
    rx_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [UART_DATA_BITS-1:0] shift, shift_n, head;
    logic push_r, push_n, ferr_set, ovr_set;
    logic overrun_r, ferr_r, empty, full, tick;

    assign tick = cnt == '0;
    // a registered push into a full FIFO is only lost if no pop frees a slot
    assign ovr_set = push_r & full & ~bus.read_enable;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s <= 1'b1;
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            shift <= '0;
            push_r <= 1'b0;
            overrun_r <= 1'b0;
            ferr_r <= 1'b0;
        end else begin
            rx_meta <= rxd;
            rx_s <= rx_meta;
            state <= state_n;
            cnt <= cnt_n;
            idx <= idx_n;
            shift <= shift_n;
            push_r <= push_n;
            overrun_r <= ovr_set | (overrun_r & ~bus.err_clear);
            ferr_r <= ferr_set | (ferr_r & ~bus.err_clear);
        end
    end

    always_comb begin
        state_n = state;
        cnt_n = tick ? cnt : cnt - 1'b1;
        idx_n = idx;
        shift_n = shift;
        push_n = 1'b0;
        ferr_set = 1'b0;
        case (state)
            IDLE: if (!rx_s) begin
                state_n = START;
                cnt_n = HALF_LOAD;
            end
            START: if (tick) begin
                state_n = rx_s ? IDLE : DATA;
                idx_n = '0;
                cnt_n = BIT_LOAD;
            end
            DATA: if (tick) begin
                shift_n = {rx_s, shift[UART_DATA_BITS-1:1]};
                idx_n = idx + 1'b1;
                cnt_n = BIT_LOAD;
                if (idx == 3'(UART_DATA_BITS - 1)) state_n = STOP;
            end
            STOP: if (tick) begin
                push_n = rx_s;
                ferr_set = ~rx_s;
                state_n = rx_s ? IDLE : WAIT_HIGH;
            end
            // hold off until the line returns high so a break is not taken as a start bit
            WAIT_HIGH: if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    uart_rx_fifo #(.FIFO_WIDTH(FIFO_WIDTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push_r),
        .push_data(shift),
        .pop(bus.read_enable),
        .head(head),
        .empty(empty),
        .full(full)
    );

    assign bus.input_ready = ~empty;
    assign bus.input_data = empty ? '0 : {{(UART_DATA_EXT - UART_DATA_BITS){1'b0}}, head};
    assign bus.overrun = overrun_r;
    assign bus.framing_error = ferr_r;
endmodule

// File: tb/tb_uart_input_buffer.sv
// tb_uart_input_buffer: scoreboard bench for uart_input_buffer at 4 clk/bit, 4-entry FIFO.
module tb_uart_input_buffer;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rxd = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];

    uart_input_buffer_if bus ();

    uart_input_buffer #(.CLK_PER_BIT(4), .FIFO_WIDTH(2)) dut (
        .clk(clk),
        .reset(reset),
        .rxd(rxd),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (4) @(negedge clk);
        end
        rxd = stop;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1);
        if (q.size() < 4) q.push_back(b);
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 100 && bus.input_ready !== 1'b1; i++) @(negedge clk);
        chk(name, 32'(bus.input_ready), 32'd1);
    endtask

    task automatic read_check(input string name);
        logic [7:0] exp;
        exp = q.pop_front();
        chk({name, "_ready"}, 32'(bus.input_ready), 32'd1);
        chk({name, "_data"}, bus.input_data, {24'b0, exp});
        bus.read_enable = 1'b1;
        @(negedge clk);
        bus.read_enable = 1'b0;
    endtask

    task automatic test_reset;
        chk("rst_ready", 32'(bus.input_ready), 32'd0);
        chk("rst_data", bus.input_data, 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        chk("rst_ferr", 32'(bus.framing_error), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_count", 32'(dut.u_fifo.count), 32'd0);
    endtask

    task automatic test_single;
        send_byte(8'hA5);
        @(negedge clk);
        chk("single_ready_early", 32'(bus.input_ready), 32'd0);
        @(negedge clk);
        chk("single_ready_latency", 32'(bus.input_ready), 32'd1);
        read_check("single");
        chk("single_empty_ready", 32'(bus.input_ready), 32'd0);
        chk("single_empty_data", bus.input_data, 32'd0);
    endtask

    task automatic test_back_to_back;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        repeat (3) @(negedge clk);
        chk("b2b_count", 32'(dut.u_fifo.count), 32'(q.size()));
        for (int i = 0; i < 3; i++) read_check("b2b");
        chk("b2b_empty", 32'(bus.input_ready), 32'd0);
    endtask

    task automatic test_overrun;
        for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i));
        repeat (3) @(negedge clk);
        chk("ovr_set", 32'(bus.overrun), 32'd1);
        chk("ovr_count", 32'(dut.u_fifo.count), 32'd4);
        bus.err_clear = 1'b1;
        @(negedge clk);
        bus.err_clear = 1'b0;
        chk("ovr_clear", 32'(bus.overrun), 32'd0);
        send_frame(8'h14, 1'b1);
        @(negedge clk);
        chk("ovr_head_before_pop", bus.input_data, {24'b0, q[0]});
        bus.read_enable = 1'b1;
        void'(q.pop_front());
        q.push_back(8'h14);
        @(negedge clk);
        bus.read_enable = 1'b0;
        chk("ovr_simul_flag", 32'(bus.overrun), 32'd0);
        chk("ovr_simul_count", 32'(dut.u_fifo.count), 32'd4);
        for (int i = 0; i < 4; i++) read_check("ovr_order");
        chk("ovr_empty", 32'(bus.input_ready), 32'd0);
    endtask

    task automatic test_framing;
        send_frame(8'h99, 1'b0);
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        chk("ferr_set", 32'(bus.framing_error), 32'd1);
        chk("ferr_discard", 32'(bus.input_ready), 32'd0);
        send_byte(8'h3C);
        wait_ready("ferr_wait");
        read_check("ferr_next");
        bus.err_clear = 1'b1;
        @(negedge clk);
        bus.err_clear = 1'b0;
        chk("ferr_clear", 32'(bus.framing_error), 32'd0);
    endtask

    task automatic test_glitch;
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        chk("glitch_ready", 32'(bus.input_ready), 32'd0);
        chk("glitch_ovr", 32'(bus.overrun), 32'd0);
        chk("glitch_ferr", 32'(bus.framing_error), 32'd0);
        chk("glitch_state", 32'(dut.state), 32'(IDLE));
        bus.read_enable = 1'b1;
        @(negedge clk);
        bus.read_enable = 1'b0;
        chk("empty_pop_count", 32'(dut.u_fifo.count), 32'd0);
        chk("empty_pop_ovr", 32'(bus.overrun), 32'd0);
    endtask

    task automatic test_reset_midframe;
        logic [7:0] b;
        b = 8'h55;
        send_frame(8'h66, 1'b0);
        repeat (6) @(negedge clk);
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (3) @(negedge clk);
        chk("mid_pre_ferr", 32'(bus.framing_error), 32'd1);
        chk("mid_pre_count", 32'(dut.u_fifo.count), 32'd2);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            repeat (4) @(negedge clk);
        end
        rxd = b[4];
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        q.delete();
        chk("mid_ready", 32'(bus.input_ready), 32'd0);
        chk("mid_ferr", 32'(bus.framing_error), 32'd0);
        chk("mid_ovr", 32'(bus.overrun), 32'd0);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        send_byte(8'h7E);
        wait_ready("mid_wait");
        repeat (2) @(negedge clk);
        chk("mid_count", 32'(dut.u_fifo.count), 32'd1);
        read_check("mid_sole");
        chk("mid_empty", 32'(bus.input_ready), 32'd0);
    endtask

    initial begin
        bus.read_enable = 1'b0;
        bus.err_clear = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        test_single();
        test_back_to_back();
        test_overrun();
        test_framing();
        test_glitch();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_input_buffer.md
Name: uart_input_buffer

Overview:
- Receive-side producer for the CPU's UART input path.
- Deserialises 8N1 UART frames from the serial pin into bytes and queues them in a small FIFO.
- Presents the FIFO head to the writeback stage as input_data/input_ready; the writeback stage pops one entry per UART read instruction with read_enable.
- Sits between the board RX pin and the write-back/PC-generate stage.

Parameters:
- CLK_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range ≥4.
- FIFO_WIDTH, 4, log2 of FIFO depth (depth = 16 bytes).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-low; state cleared on any rising clk edge where reset==0
- rxd  input  1  asynchronous serial input, idle high
- read_enable  input  1  pop FIFO head this cycle (from writeback stage)
- err_clear  input  1  clears overrun and framing_error
- input_ready  output  1  FIFO non-empty
- input_data  output  32  {24'b0, head byte}; valid only while input_ready==1
- overrun  output  1  sticky: a byte was dropped because the FIFO was full
- framing_error  output  1  sticky: stop bit sampled low

Behaviour:
- Reset values: input_ready=0, input_data=0, overrun=0, framing_error=0, FIFO empty, FSM=IDLE, synchroniser flops=1.
- rxd passes through a 2-flop synchroniser (rx_s); all decisions use rx_s.
- FSM states (package enum): IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: on rx_s==0, load baud counter, go to START.
- START: sample at CLK_PER_BIT/2 cycles (integer division).
  - rx_s==1: glitch, go to IDLE with no push.
  - rx_s==0: go to DATA, bit index=0.
- DATA: sample every CLK_PER_BIT cycles, LSB first, shifting into an 8-bit register. After bit 7 is sampled, go to STOP.
- STOP: sample after CLK_PER_BIT cycles.
  - rx_s==1: assert a one-cycle push, go to IDLE.
  - rx_s==0: set framing_error, discard byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. This prevents a break condition being treated as a start bit.
- FIFO: circular buffer of 2^FIFO_WIDTH bytes.
  - Read/write pointers and count are FIFO_WIDTH+1 bits; pointers wrap modulo depth.
- Push when not full: byte is written; input_ready rises the cycle after the push cycle (if previously empty).
- Push when full and read_enable==0: byte dropped, overrun set, count unchanged.
- Push when full and read_enable==1 in the same cycle: the pop and push both succeed; count stays at depth; overrun is not set.
- Push and pop when 0<count<depth: count unchanged; head advances.
- read_enable when empty: ignored, with no pointer movement and no error.
- input_data is combinational from the head entry and is zero-extended. It updates the cycle after a pop to the next entry; it is 0 when empty.
- err_clear clears both sticky flags. If a new error event occurs in the same cycle, the set wins.
- Reset asserted mid-frame: frame abandoned, FIFO flushed, flags cleared. After reset deasserts, a frame whose start bit was missed is not received; if rx_s is low at that point, the FSM starts from IDLE and may capture a partial frame, which typically ends in framing_error.
- Latency from the stop-bit sample edge to input_ready high: 2 clk cycles (push register, then FIFO count update).

Decomposition:
- Package uart_pkg holds:
  - rx_state_t enum (IDLE, START, DATA, STOP, WAIT_HIGH)
  - UART_DATA_BITS=8
  - UART_DATA_EXT=32 (width of input_data)
- Sub-module uart_rx_fifo, parameterised by FIFO_WIDTH:
  - ports: clk, reset, push, push_data[7:0], pop, head[7:0], empty, full
  - implements the full/empty and simultaneous push/pop rules above.
- The top level holds the synchroniser, baud counter, FSM, sticky flags and zero-extension.

Test Plan (CLK_PER_BIT=4, FIFO_WIDTH=2):
- Single frame 0xA5 driven at 4 clk/bit → input_ready=1 two cycles after the stop sample; input_data=0x000000A5; pulse read_enable → input_ready=0, input_data=0.
- Send 0x01, 0x02, 0x03 back-to-back without pops → count=3; successive pops yield 0x01, 0x02, 0x03 in order, then input_ready=0.
- Fill 4 entries (0x10–0x13), send 0x14 with read_enable low → overrun=1; FIFO still holds 0x10–0x13. Repeat the 5th byte with read_enable pulsed on the push cycle → overrun stays 0; final order 0x11–0x14.
- Frame with stop bit 0, rxd held low 20 cycles, then high, then valid 0x3C → framing_error=1; 0x3C received correctly; err_clear → framing_error=0.
- 1-cycle low glitch on rxd while idle → no push, no flags, FSM back in IDLE.
- Assert reset (0) during bit 4 of a frame with 2 bytes queued → next cycle input_ready=0, flags=0. Release reset with rxd high, send 0x7E → received as the sole entry.
